// File: rtl/rr_arb16_pkg.sv
// rr_arb16_pkg
//   Shared definitions for the 16-requester round-robin arbiter:
//   requester count, index width, hold-counter width, the FSM state
//   type and a one-hot decode helper.
package rr_arb16_pkg;

    localparam int unsigned NREQ = 16;
    localparam int unsigned IDXW = 4;
    localparam int unsigned HCW  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arb16_rot_prio16x4.sv
// rot_prio16x4
//   Combinational rotating-priority search over a 16-bit vector.
//   Returns the first set bit at or after 'start', wrapping modulo 16,
//   optionally skipping the index 'excl'.
// Ports:
//   vec      in  16  candidate vector
//   start    in   4  first index examined
//   excl     in   4  index to ignore when excl_en is high
//   excl_en  in   1  enable for excl
//   idx      out  4  index of the first eligible set bit (0 if none)
//   found    out  1  high when an eligible set bit exists
module rot_prio16x4
    import rr_arb16_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    input  logic [IDXW-1:0] start,
    input  logic [IDXW-1:0] excl,
    input  logic            excl_en,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    logic [IDXW-1:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // 4-bit addition wraps naturally modulo 16
            pos = start + IDXW'(i);
            if (!found && vec[pos] && !(excl_en && (pos == excl))) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_arb16.sv
// rr_arb16
//   Round-robin arbiter for one shared resource and 16 requesters.
//   An owner keeps the grant while it requests; after MAX_HOLD
//   consecutive cycles it is preempted if anyone else is waiting
//   (MAX_HOLD = 0 disables preemption). Handover is same-edge.
// Parameters:
//   MAX_HOLD  hold limit in cycles, 0..255, 0 = unlimited
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in  16  request vector, bit i = requester i
//   gnt      out 16  registered one-hot grant, zero when idle
//   gnt_id   out  4  registered binary index of the owner, 0 when idle
//   gnt_vld  out  1  registered, high while a grant is active
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_id,
    output logic            gnt_vld
);

    localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);

    state_t          state, state_nx;
    logic [IDXW-1:0] ptr, ptr_nx;
    logic [HCW-1:0]  hold_cnt, hold_nx;
    logic [IDXW-1:0] id_nx;
    logic [NREQ-1:0] gnt_nx;
    logic            vld_nx;

    logic [IDXW-1:0] s_start;
    logic            s_excl_en;
    logic [IDXW-1:0] s_idx;
    logic            s_found;

    // One search serves every case: from IDLE it starts at ptr; while
    // granting it starts after the owner and skips it. On release the
    // owner's req bit is already 0, so the exclusion is harmless there,
    // and s_found doubles as "some other requester is waiting".
    assign s_start   = (state == GRANT) ? gnt_id + IDXW'(1) : ptr;
    assign s_excl_en = (state == GRANT);

    rot_prio16x4 u_search (
        .vec     (req),
        .start   (s_start),
        .excl    (gnt_id),
        .excl_en (s_excl_en),
        .idx     (s_idx),
        .found   (s_found)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        id_nx    = gnt_id;
        unique case (state)
            IDLE: begin
                if (s_found) begin
                    state_nx = GRANT;
                    id_nx    = s_idx;
                    hold_nx  = HCW'(1);
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    ptr_nx = gnt_id + IDXW'(1);
                    if (s_found) begin
                        id_nx   = s_idx;
                        hold_nx = HCW'(1);
                    end else begin
                        state_nx = IDLE;
                        id_nx    = '0;
                        hold_nx  = '0;
                    end
                end else if ((HOLD_LIM != '0) && (hold_cnt >= HOLD_LIM) && s_found) begin
                    ptr_nx  = gnt_id + IDXW'(1);
                    id_nx   = s_idx;
                    hold_nx = HCW'(1);
                end else if ((HOLD_LIM != '0) && (hold_cnt < HOLD_LIM)) begin
                    hold_nx = hold_cnt + HCW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        gnt_nx = (state_nx == GRANT) ? onehot(id_nx) : '0;
        vld_nx = (state_nx == GRANT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            gnt      <= gnt_nx;
            gnt_id   <= id_nx;
            gnt_vld  <= vld_nx;
        end
    end

endmodule

// File: tb/tb_rr_arb16.sv
// tb_rr_arb16
//   Self-checking bench for rr_arb16. Three instances share clock,
//   reset and request: default hold limit (8), limit 4 and unlimited (0).
module tb_rr_arb16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;

    logic [15:0] g8, g4, g0;
    logic [3:0]  id8, id4, id0;
    logic        v8, v4, v0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rr_arb16 u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(g8), .gnt_id(id8), .gnt_vld(v8)
    );
    rr_arb16 #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(g4), .gnt_id(id4), .gnt_vld(v4)
    );
    rr_arb16 #(.MAX_HOLD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(g0), .gnt_id(id0), .gnt_vld(v0)
    );

    typedef struct {
        logic        rst;
        logic [15:0] rq;
        logic [15:0] eg;
        logic [3:0]  eid;
        logic        ev;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int which,
                       input logic [15:0] eg, input logic [3:0] eid, input logic ev);
        logic [15:0] ag;
        logic [3:0]  aid;
        logic        av;
        case (which)
            4:       begin ag = g4; aid = id4; av = v4; end
            0:       begin ag = g0; aid = id0; av = v0; end
            default: begin ag = g8; aid = id8; av = v8; end
        endcase
        total++;
        if (ag === eg && aid === eid && av === ev) begin
            passed++;
        end else begin
            $display("FAIL %s dut%0d t=%0t: got gnt=%h id=%0d vld=%b, want gnt=%h id=%0d vld=%b",
                     name, which, $time, ag, aid, av, eg, eid, ev);
        end
    endtask

    // Apply req before the next rising edge, then sample 1 time unit after it.
    task automatic step(input logic [15:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        logic       hit;

        rst_n = 1'b0;
        req   = '0;
        #12;
        chk("reset_state", 8, 16'h0000, 4'd0, 1'b0);
        chk("reset_state", 4, 16'h0000, 4'd0, 1'b0);
        chk("reset_state", 0, 16'h0000, 4'd0, 1'b0);

        // rst, req, expected gnt, gnt_id, gnt_vld (checked on the default instance)
        tbl[0]  = '{1'b1, 16'h0020, 16'h0020, 4'd5,  1'b1};
        tbl[1]  = '{1'b0, 16'h0020, 16'h0020, 4'd5,  1'b1};
        tbl[2]  = '{1'b0, 16'h0020, 16'h0020, 4'd5,  1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0};
        tbl[4]  = '{1'b0, 16'h0041, 16'h0040, 4'd6,  1'b1};  // ptr is 6 after releasing 5
        tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0};
        tbl[6]  = '{1'b1, 16'h0408, 16'h0008, 4'd3,  1'b1};
        tbl[7]  = '{1'b0, 16'h0408, 16'h0008, 4'd3,  1'b1};
        tbl[8]  = '{1'b0, 16'h0400, 16'h0400, 4'd10, 1'b1};  // same-edge handover
        tbl[9]  = '{1'b0, 16'h0400, 16'h0400, 4'd10, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0};
        tbl[11] = '{1'b0, 16'h8000, 16'h8000, 4'd15, 1'b1};
        tbl[12] = '{1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0};  // ptr wraps to 0
        tbl[13] = '{1'b0, 16'h4001, 16'h0001, 4'd0,  1'b1};
        tbl[14] = '{1'b0, 16'h4000, 16'h4000, 4'd14, 1'b1};
        tbl[15] = '{1'b0, 16'h0000, 16'h0000, 4'd0,  1'b0};

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].rq);
            chk($sformatf("vec%0d", i), 8, tbl[i].eg, tbl[i].eid, tbl[i].ev);
        end

        // Full-load rotation with hold limit 4
        do_reset();
        for (int c = 0; c < 68; c++) begin
            step(16'hFFFF);
            e = 4'((c / 4) % 16);
            chk($sformatf("rotate_c%0d", c), 4, 16'h0001 << e, e, 1'b1);
        end

        // Two contenders under the default limit of 8
        do_reset();
        for (int c = 0; c < 24; c++) begin
            step(16'h0003);
            e = 4'((c / 8) % 2);
            chk($sformatf("preempt8_c%0d", c), 8, 16'h0001 << e, e, 1'b1);
        end

        // Saturated owner is preempted the moment another request appears
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(16'h0001);
            if (c == 11) chk("sat_hold", 8, 16'h0001, 4'd0, 1'b1);
        end
        step(16'h0003);
        chk("sat_preempt", 8, 16'h0002, 4'd1, 1'b1);
        chk("sat_preempt", 4, 16'h0002, 4'd1, 1'b1);
        chk("sat_unlimited", 0, 16'h0001, 4'd0, 1'b1);

        // A request that comes and goes while another owns is forgotten
        do_reset();
        step(16'h0001);
        step(16'h0005);
        step(16'h0001);
        chk("transient_owner", 8, 16'h0001, 4'd0, 1'b1);
        step(16'h0000);
        chk("transient_forgot", 8, 16'h0000, 4'd0, 1'b0);

        // Unlimited hold
        do_reset();
        for (int c = 0; c < 100; c++) begin
            step(16'h0084);
            if (c % 10 == 9 || c == 0) chk($sformatf("unlim_c%0d", c), 0, 16'h0004, 4'd2, 1'b1);
        end
        step(16'h0080);
        chk("unlim_handover", 0, 16'h0080, 4'd7, 1'b1);
        step(16'h0000);
        chk("unlim_idle", 0, 16'h0000, 4'd0, 1'b0);

        // Asynchronous reset while requester 9 owns
        do_reset();
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            step(16'hFFFF);
            if (id4 == 4'd9 && v4) hit = 1'b1;
        end
        total++;
        if (hit) passed++;
        else $display("FAIL wait_id9: got id=%0d, want 9 within 100 cycles", id4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4, 16'h0000, 4'd0, 1'b0);
        chk("async_reset", 8, 16'h0000, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_first", 4, 16'h0001, 4'd0, 1'b1);
        chk("post_reset_first", 8, 16'h0001, 4'd0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
